// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding request sequencer between the pipeline memory
// stage and the DRAM block. It accepts one load or store per handshake, drives
// a one-cycle RD/WR strobe, waits a fixed access latency and then returns load
// data or a store acknowledge. Every output comes straight from a flop.
module mem_ctrl #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic        i_req_write,
    input  logic [15:0] i_req_addr,
    input  logic [15:0] i_req_data,
    output logic        o_req_ready,
    output logic        o_resp_valid,
    output logic [15:0] o_resp_data,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_data_in,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    input  logic [15:0] i_mem_data_out
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_accept;
    logic            w_cnt_zero;
    logic            w_capture;
    logic [CW-1:0]   r_cnt;
    logic            r_wr;
    logic            r_req_ready;
    logic            r_resp_valid;
    logic [DW-1:0]   r_resp_data;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_data_in;
    logic            r_mem_rd;
    logic            r_mem_wr;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a handshake is only possible while idle, so a request
    // presented during an access simply waits for the controller to return.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_cnt_zero   = (r_cnt == CW'(0));
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_cnt_zero) begin
                    w_capture    = ~r_wr;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Handshake and response flags, registered from the next state so they
    // line up with the state they describe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
        end else begin
            r_req_ready  <= (w_state_next == S_IDLE);
            r_resp_valid <= (w_state_next == S_DONE);
        end
    end

    // Request capture; address and store data stay put until the next accept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem_addr    <= AW'(0);
            r_mem_data_in <= DW'(0);
            r_wr          <= 1'b0;
        end else if (w_accept) begin
            r_mem_addr <= i_req_addr;
            r_wr       <= i_req_write;
            if (i_req_write) begin
                r_mem_data_in <= i_req_data;
            end
        end
    end

    // DRAM strobes: high for exactly the ISSUE cycle of each access.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
        end else begin
            r_mem_rd <= w_accept & ~i_req_write;
            r_mem_wr <= w_accept & i_req_write;
        end
    end

    // Access-window counter: loaded in ISSUE, counts down through WAIT, parks at 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= CW'(0);
        end else if (r_state == S_ISSUE) begin
            r_cnt <= CW'(LATENCY - 1);
        end else if ((r_state == S_WAIT) && !w_cnt_zero) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Load data capture on the final WAIT edge; stores leave it untouched.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_resp_data <= DW'(0);
        end else if (w_capture) begin
            r_resp_data <= i_mem_data_out;
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_data   = r_resp_data;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_data_in = r_mem_data_in;
    assign o_mem_rd      = r_mem_rd;
    assign o_mem_wr      = r_mem_wr;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven bench for mem_ctrl with a response scoreboard,
// a small latency-accurate DRAM model, and extra instances at LATENCY 1 and 15.
module tb_mem_ctrl;

    localparam int LAT = 2;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] resp;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] resp;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_write, req_ready, resp_valid, mem_rd, mem_wr;
    logic [15:0] req_addr, req_data, resp_data, mem_addr, mem_data_in, mem_data_out;

    logic        x_valid;
    logic        x_write;
    logic [15:0] x_addr, x_data;
    logic        xa_ready, xa_resp_valid, xa_mem_rd, xa_mem_wr;
    logic [15:0] xa_resp_data, xa_mem_addr, xa_mem_data_in;
    logic        xb_ready, xb_resp_valid, xb_mem_rd, xb_mem_wr;
    logic [15:0] xb_resp_data, xb_mem_addr, xb_mem_data_in;

    mem_ctrl #(.LATENCY(LAT)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_write(req_write),
        .i_req_addr(req_addr), .i_req_data(req_data),
        .o_req_ready(req_ready), .o_resp_valid(resp_valid), .o_resp_data(resp_data),
        .o_mem_addr(mem_addr), .o_mem_data_in(mem_data_in),
        .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .i_mem_data_out(mem_data_out)
    );

    mem_ctrl #(.LATENCY(1)) u_dut_l1 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(x_valid), .i_req_write(x_write),
        .i_req_addr(x_addr), .i_req_data(x_data),
        .o_req_ready(xa_ready), .o_resp_valid(xa_resp_valid), .o_resp_data(xa_resp_data),
        .o_mem_addr(xa_mem_addr), .o_mem_data_in(xa_mem_data_in),
        .o_mem_rd(xa_mem_rd), .o_mem_wr(xa_mem_wr), .i_mem_data_out(16'hC0DE)
    );

    mem_ctrl #(.LATENCY(15)) u_dut_l15 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(x_valid), .i_req_write(x_write),
        .i_req_addr(x_addr), .i_req_data(x_data),
        .o_req_ready(xb_ready), .o_resp_valid(xb_resp_valid), .o_resp_data(xb_resp_data),
        .o_mem_addr(xb_mem_addr), .o_mem_data_in(xb_mem_data_in),
        .o_mem_rd(xb_mem_rd), .o_mem_wr(xb_mem_wr), .i_mem_data_out(16'h7E57)
    );

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;
    int strobe_cnt = 0;
    int resp_pulses = 0;
    logic [15:0] last_din;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // DRAM model: read data becomes valid LAT edges after the strobe is sampled.
    logic [15:0] dram [0:255];
    logic [15:0] dram_q = 16'h0000;
    int          dram_age = 99;
    always @(posedge clk) begin
        if (mem_wr) dram[mem_addr[7:0]] <= mem_data_in;
        if (mem_rd) begin
            dram_q   <= dram[mem_addr[7:0]];
            dram_age <= 1;
        end else if (dram_age < 99) begin
            dram_age <= dram_age + 1;
        end
    end
    assign mem_data_out = (dram_age >= LAT) ? dram_q : 16'hDEAD;

    // Monitor: strobe legality, address hold and scoreboard pop on each response.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd || mem_wr) begin
                chk("strobe_excl", 32'(mem_rd & mem_wr), 32'(0));
                if (sb.size() > 0) begin
                    chk("strobe_kind", 32'(mem_wr), 32'(sb[0].wr));
                    chk("strobe_addr", 32'(mem_addr), 32'(sb[0].addr));
                    chk("strobe_din", 32'(mem_data_in), 32'(sb[0].din));
                end
                strobe_cnt++;
            end
            if (sb.size() > 0 && cycle_cnt >= sb[0].acc)
                chk("addr_hold", 32'(mem_addr), 32'(sb[0].addr));
            if (resp_valid) begin
                resp_pulses++;
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 32'(1), 32'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_data", 32'(resp_data), 32'(mon_e.resp));
                    // latency counted to the edge at which the pipeline captures RespValid
                    chk("resp_latency", 32'(cycle_cnt - mon_e.acc + 1), 32'(LAT + 2));
                    chk("strobe_count", 32'(strobe_cnt), 32'(1));
                end
                strobe_cnt = 0;
            end
        end
    end

    task automatic drive_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                             input logic [15:0] resp, input bit hold, output int acc);
        exp_t it;
        bit   done;
        done = 1'b0;
        acc  = -1;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
        for (int i = 0; i < 50 && !done; i++) begin
            if (req_ready) begin
                @(posedge clk); #1;
                acc     = cycle_cnt;
                done    = 1'b1;
                it.wr   = w;
                it.addr = a;
                it.din  = w ? d : last_din;
                it.resp = resp;
                it.acc  = acc;
                sb.push_back(it);
                if (w) last_din = d;
                if (!hold) req_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            chk("accept_timeout", 32'(0), 32'(1));
            req_valid = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'(1));
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'(0));
        chk({tag, "_resp_data"}, 32'(resp_data), 32'(0));
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
        chk({tag, "_mem_din"}, 32'(mem_data_in), 32'(0));
        chk({tag, "_mem_rd"}, 32'(mem_rd), 32'(0));
        chk({tag, "_mem_wr"}, 32'(mem_wr), 32'(0));
    endtask

    int acc, acc1, acc2, p0, lat_a, lat_b, pulses_a, pulses_b;

    initial begin
        tbl[0]  = '{1'b1, 16'h0003, 16'hBEEF, 16'h0000};
        tbl[1]  = '{1'b0, 16'h0003, 16'h9999, 16'hBEEF};
        tbl[2]  = '{1'b1, 16'h0010, 16'h1234, 16'hBEEF};
        tbl[3]  = '{1'b0, 16'h0010, 16'h9999, 16'h1234};
        tbl[4]  = '{1'b1, 16'h0011, 16'h5555, 16'h1234};
        tbl[5]  = '{1'b0, 16'h0011, 16'h9999, 16'h5555};
        tbl[6]  = '{1'b1, 16'h0001, 16'h1111, 16'h5555};
        tbl[7]  = '{1'b1, 16'h0002, 16'h2222, 16'h5555};
        tbl[8]  = '{1'b1, 16'hFFFF, 16'hA5A5, 16'h5555};
        tbl[9]  = '{1'b0, 16'hFFFF, 16'h9999, 16'hA5A5};
        tbl[10] = '{1'b0, 16'h0003, 16'h9999, 16'hBEEF};
        tbl[11] = '{1'b1, 16'h0003, 16'h0F0F, 16'hBEEF};
        tbl[12] = '{1'b0, 16'h0003, 16'h9999, 16'h0F0F};

        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0; req_data = 16'h0;
        x_valid = 1'b0; x_write = 1'b0; x_addr = 16'h0042; x_data = 16'h0;
        last_din = 16'h0;
        #1 rst = 1'b1;
        #1 chk_reset_outputs("por");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // LATENCY 1 and 15 instances: single load each, latency and data.
        @(negedge clk);
        x_valid = 1'b1;
        @(posedge clk); #1;
        x_valid = 1'b0;
        acc = cycle_cnt;
        chk("l1_rd", 32'(xa_mem_rd), 32'(1));
        chk("l1_wr", 32'(xa_mem_wr), 32'(0));
        chk("l1_addr", 32'(xa_mem_addr), 32'h0042);
        chk("l1_din", 32'(xa_mem_data_in), 32'(0));
        chk("l1_ready", 32'(xa_ready), 32'(0));
        chk("l15_rd", 32'(xb_mem_rd), 32'(1));
        chk("l15_wr", 32'(xb_mem_wr), 32'(0));
        chk("l15_addr", 32'(xb_mem_addr), 32'h0042);
        chk("l15_din", 32'(xb_mem_data_in), 32'(0));
        chk("l15_ready", 32'(xb_ready), 32'(0));
        lat_a = -1; lat_b = -1; pulses_a = 0; pulses_b = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (xa_resp_valid) begin
                pulses_a++;
                lat_a = cycle_cnt - acc + 1;
                chk("l1_data", 32'(xa_resp_data), 32'hC0DE);
            end
            if (xb_resp_valid) begin
                pulses_b++;
                lat_b = cycle_cnt - acc + 1;
                chk("l15_data", 32'(xb_resp_data), 32'h7E57);
            end
        end
        chk("l1_latency", 32'(lat_a), 32'(3));
        chk("l15_latency", 32'(lat_b), 32'(17));
        chk("l1_pulses", 32'(pulses_a), 32'(1));
        chk("l15_pulses", 32'(pulses_b), 32'(1));
        chk("l1_ready_back", 32'(xa_ready), 32'(1));
        chk("l15_ready_back", 32'(xb_ready), 32'(1));

        // Main table: stores and loads, one at a time.
        for (int i = 0; i < 13; i++)
            drive_req(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].resp, 1'b0, acc);

        // Held ReqValid: second load accepted exactly LAT+3 cycles after the first.
        drive_req(1'b0, 16'h0001, 16'h0, 16'h1111, 1'b1, acc1);
        drive_req(1'b0, 16'h0002, 16'h0, 16'h2222, 1'b0, acc2);
        chk("b2b_spacing", 32'(acc2 - acc1), 32'(LAT + 3));
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        chk("drain_held", 32'(sb.size()), 32'(0));

        // Asynchronous reset while in WAIT: outputs clear with no clock edge.
        drive_req(1'b0, 16'h0010, 16'h0, 16'h1234, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk_reset_outputs("rst_wait");
        sb.delete(); strobe_cnt = 0; last_din = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        p0 = resp_pulses;
        for (int i = 0; i < 8; i++) @(negedge clk);
        chk("no_resp_after_reset", 32'(resp_pulses - p0), 32'(0));

        // Reset mid-access with the request still held: accepted at first edge after release.
        drive_req(1'b0, 16'h0011, 16'h0, 16'h5555, 1'b1, acc);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        sb.delete(); strobe_cnt = 0; last_din = 16'h0;
        chk("rstb_ready", 32'(req_ready), 32'(1));
        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{1'b0, 16'h0011, 16'h0000, 16'h5555, cycle_cnt + 1});
        p0 = resp_pulses;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstb_first_edge_rd", 32'(mem_rd), 32'(1));
        chk("rstb_first_edge_addr", 32'(mem_addr), 32'h0011);
        for (int i = 0; i < 12; i++) @(negedge clk);
        chk("rstb_one_resp", 32'(resp_pulses - p0), 32'(1));
        chk("rstb_drain", 32'(sb.size()), 32'(0));

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
